// File: rtl/bram_save_pkg.sv
// bram_save_pkg
// Shared definitions for the backup-RAM save sequencer:
//   state_t          - sequencer states
//   SECTORS_DEFAULT  - sectors moved per load/save transfer
//   FMT_HEADER       - the four header words written by a format
package bram_save_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_END,
        ST_NEXT,
        ST_FORMAT
    } state_t;

    localparam int SECTORS_DEFAULT = 16;

    localparam logic [15:0] FMT_HEADER [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

endpackage

// File: rtl/bram_save_sequencer.sv
// bram_save_sequencer
// Sequences SECTORS-sector load/save transfers between the HPS SD sector
// channel and backup-RAM port B, writes the 4-word format header, and
// (optionally) tracks unsaved core writes for autosave.
//
// Optional feature: define BRAM_AUTOSAVE_EN to enable pending tracking and
// the autosave trigger; otherwise pending is tied low.
//
// Ports:
//   clk_sys, reset_n           - clock, asynchronous active-low reset
//   bk_ena                     - save file mounted and writable
//   load_req/save_req/format_req - level requests, acted on at rising edge
//   mount_done                 - pulse, starts a load like a load_req edge
//   osd_open, autosave, core_wr - autosave inputs
//   sd_lba, sd_rd, sd_wr       - sector request to the HPS
//   sd_ack, sd_buff_addr, sd_buff_wr - HPS transfer handshake and buffer
//   bram_b_addr, bram_b_we     - port-B address/write enable
//   bram_b_fmt, fmt_data       - port-B data select and header word
//   busy, loading, pending     - status
module bram_save_sequencer
    import bram_save_pkg::*;
#(
    parameter int SECTORS = SECTORS_DEFAULT,
    parameter int LBA_W   = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        bk_ena,
    input  logic        load_req,
    input  logic        save_req,
    input  logic        format_req,
    input  logic        mount_done,
    input  logic        osd_open,
    input  logic        autosave,
    input  logic        core_wr,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [7:0]  sd_buff_addr,
    input  logic        sd_buff_wr,
    output logic [11:0] bram_b_addr,
    output logic        bram_b_we,
    output logic        bram_b_fmt,
    output logic [15:0] fmt_data,
    output logic        busy,
    output logic        loading,
    output logic        pending
);

    localparam logic [LBA_W-1:0] LBA_LAST = LBA_W'(SECTORS - 1);

    state_t           state, state_nxt;
    logic             load_prev, save_prev, format_prev, ack_prev;
    logic [LBA_W-1:0] lba_q, lba_nxt;
    logic             sd_rd_nxt, sd_wr_nxt, loading_nxt, busy_nxt, fmt_sel_nxt;
    logic [1:0]       fmt_cnt, fmt_cnt_nxt;
    logic [15:0]      fmt_data_nxt;
    logic             save_start;
    logic             auto_edge;

    logic load_edge, save_edge, format_edge, ack_rise, ack_fall;
    assign load_edge   = load_req & ~load_prev;
    assign save_edge   = save_req & ~save_prev;
    assign format_edge = format_req & ~format_prev;
    assign ack_rise    = sd_ack & ~ack_prev;
    assign ack_fall    = ~sd_ack & ack_prev;

`ifdef BRAM_AUTOSAVE_EN
    logic trig, trig_prev;
    assign trig      = pending & osd_open & autosave;
    assign auto_edge = trig & ~trig_prev;

    // Pending tracks core writes made while the OSD is closed; starting any
    // save clears it, and that clear beats a write in the same cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_prev <= trig;
            if (save_start)
                pending <= 1'b0;
            else if (core_wr & bk_ena & ~osd_open)
                pending <= 1'b1;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = core_wr ^ autosave ^ osd_open ^ save_start;
    assign auto_edge     = 1'b0;
    assign pending       = 1'b0;
`endif

    // Next-state and registered-output logic. Events arriving outside IDLE
    // are dropped because the edge registers keep updating every cycle.
    // A format spends one entry cycle with bram_b_fmt low while the first
    // header word is loaded, then writes one word per cycle.
    always_comb begin
        state_nxt    = state;
        lba_nxt      = lba_q;
        sd_rd_nxt    = sd_rd;
        sd_wr_nxt    = sd_wr;
        loading_nxt  = loading;
        fmt_sel_nxt  = bram_b_fmt;
        fmt_cnt_nxt  = fmt_cnt;
        fmt_data_nxt = fmt_data;
        save_start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (format_edge) begin
                    state_nxt   = ST_FORMAT;
                    fmt_cnt_nxt = 2'd0;
                    fmt_sel_nxt = 1'b0;
                end else if (bk_ena && (load_edge || mount_done)) begin
                    state_nxt   = ST_REQ;
                    lba_nxt     = '0;
                    loading_nxt = 1'b1;
                end else if (bk_ena && (save_edge || auto_edge)) begin
                    state_nxt   = ST_REQ;
                    lba_nxt     = '0;
                    loading_nxt = 1'b0;
                    save_start  = 1'b1;
                end
            end
            ST_REQ: begin
                sd_rd_nxt = loading;
                sd_wr_nxt = ~loading;
                if (ack_rise) begin
                    sd_rd_nxt = 1'b0;
                    sd_wr_nxt = 1'b0;
                    state_nxt = ST_WAIT_END;
                end
            end
            ST_WAIT_END: begin
                if (ack_fall) begin
                    if (lba_q == LBA_LAST) begin
                        state_nxt   = ST_IDLE;
                        loading_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                lba_nxt   = lba_q + LBA_W'(1);
                state_nxt = ST_REQ;
            end
            ST_FORMAT: begin
                if (!bram_b_fmt) begin
                    fmt_sel_nxt  = 1'b1;
                    fmt_cnt_nxt  = 2'd0;
                    fmt_data_nxt = FMT_HEADER[0];
                end else if (fmt_cnt == 2'd3) begin
                    fmt_sel_nxt  = 1'b0;
                    fmt_cnt_nxt  = 2'd0;
                    fmt_data_nxt = 16'h0000;
                    state_nxt    = ST_IDLE;
                end else begin
                    fmt_cnt_nxt  = fmt_cnt + 2'd1;
                    fmt_data_nxt = FMT_HEADER[fmt_cnt + 2'd1];
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State, edge history and all registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            load_prev   <= 1'b0;
            save_prev   <= 1'b0;
            format_prev <= 1'b0;
            ack_prev    <= 1'b0;
            lba_q       <= '0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            loading     <= 1'b0;
            busy        <= 1'b0;
            bram_b_fmt  <= 1'b0;
            fmt_cnt     <= 2'd0;
            fmt_data    <= 16'h0000;
        end else begin
            state       <= state_nxt;
            load_prev   <= load_req;
            save_prev   <= save_req;
            format_prev <= format_req;
            ack_prev    <= sd_ack;
            lba_q       <= lba_nxt;
            sd_rd       <= sd_rd_nxt;
            sd_wr       <= sd_wr_nxt;
            loading     <= loading_nxt;
            busy        <= busy_nxt;
            bram_b_fmt  <= fmt_sel_nxt;
            fmt_cnt     <= fmt_cnt_nxt;
            fmt_data    <= fmt_data_nxt;
        end
    end

    assign sd_lba = 32'(lba_q);

    // Port B follows the HPS buffer directly during transfers so buffer
    // writes land in the same cycle; only loads write the RAM.
    always_comb begin
        bram_b_addr = 12'({lba_q, sd_buff_addr});
        bram_b_we   = 1'b0;
        if (state == ST_FORMAT) begin
            bram_b_addr = {10'd0, fmt_cnt};
            bram_b_we   = bram_b_fmt;
        end else if (state != ST_IDLE) begin
            bram_b_we = sd_buff_wr & sd_ack & loading;
        end
    end

endmodule

// File: tb/tb_bram_save_sequencer.sv
// tb_bram_save_sequencer
// Directed bench for bram_save_sequencer: reset state, full load and save
// against an HPS model, format header, request priority, bk_ena gating,
// autosave/pending (BRAM_AUTOSAVE_EN) and asynchronous reset mid-load.
module tb_bram_save_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        bk_ena, load_req, save_req, format_req, mount_done;
    logic        osd_open, autosave, core_wr;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [7:0]  sd_buff_addr;
    logic        sd_buff_wr;
    logic [11:0] bram_b_addr;
    logic        bram_b_we, bram_b_fmt;
    logic [15:0] fmt_data;
    logic        busy, loading, pending;

    localparam logic [15:0] HDR [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

    int total = 0;
    int bad = 0;
    int totalWe = 0;

    bram_save_sequencer dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .bk_ena       (bk_ena),
        .load_req     (load_req),
        .save_req     (save_req),
        .format_req   (format_req),
        .mount_done   (mount_done),
        .osd_open     (osd_open),
        .autosave     (autosave),
        .core_wr      (core_wr),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_wr   (sd_buff_wr),
        .bram_b_addr  (bram_b_addr),
        .bram_b_we    (bram_b_we),
        .bram_b_fmt   (bram_b_fmt),
        .fmt_data     (fmt_data),
        .busy         (busy),
        .loading      (loading),
        .pending      (pending)
    );

    // 100 MHz system clock.
    always #5 clk_sys = ~clk_sys;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drives the three request levels just after a falling edge.
    task automatic applyStimulus(input logic ld, input logic sv, input logic fm);
        @(negedge clk_sys);
        load_req   = ld;
        save_req   = sv;
        format_req = fm;
    endtask

    // HPS model for one sector whose request is already visible: acks,
    // streams 256 buffer words, drops ack and then checks the gap to the
    // next request, or the return to idle after the last sector.
    task automatic serveSector(input logic isLoad, input int lba);
        int weCount = 0;
        int addrErr = 0;
        int n = 0;
        checkOutput("sd_rd", 32'(sd_rd), isLoad ? 32'd1 : 32'd0);
        checkOutput("sd_wr", 32'(sd_wr), isLoad ? 32'd0 : 32'd1);
        checkOutput("sd_lba", sd_lba, 32'(lba));
        checkOutput("loading", 32'(loading), isLoad ? 32'd1 : 32'd0);
        sd_ack = 1'b1;
        for (int w = 0; w < 256; w++) begin
            sd_buff_addr = 8'(w);
            sd_buff_wr   = 1'b1;
            #1;
            if (bram_b_we) begin
                weCount++;
                if (bram_b_addr !== {lba[3:0], w[7:0]}) addrErr++;
            end
            @(negedge clk_sys);
        end
        sd_buff_wr = 1'b0;
        checkOutput("req_clear", 32'({sd_rd, sd_wr}), 32'd0);
        checkOutput("we_count", 32'(weCount), isLoad ? 32'd256 : 32'd0);
        checkOutput("we_addr_err", 32'(addrErr), 32'd0);
        totalWe += weCount;
        sd_ack = 1'b0;
        if (lba < 15) begin
            do begin
                @(negedge clk_sys);
                n++;
            end while (!(sd_rd || sd_wr) && n < 20);
            checkOutput("gap", 32'(n), 32'd3);
        end else begin
            @(negedge clk_sys);
            checkOutput("busy_end", 32'(busy), 32'd0);
            checkOutput("loading_end", 32'(loading), 32'd0);
        end
    endtask

    // Walks the entry cycle, the four header writes and the return to idle.
    task automatic checkFormat();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_sys);
            checkOutput("fmt_busy", 32'(busy), (k < 5) ? 32'd1 : 32'd0);
            checkOutput("fmt_we", 32'(bram_b_we), (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
            if (k >= 1 && k <= 4) begin
                checkOutput("fmt_addr", 32'(bram_b_addr), 32'(k - 1));
                checkOutput("fmt_data", 32'(fmt_data), 32'(HDR[k - 1]));
                checkOutput("fmt_sel", 32'(bram_b_fmt), 32'd1);
            end
        end
    endtask

    // Main directed sequence.
    initial begin
        int reqCount;
        reset_n = 1'b0; bk_ena = 1'b1;
        load_req = 1'b0; save_req = 1'b0; format_req = 1'b0; mount_done = 1'b0;
        osd_open = 1'b0; autosave = 1'b0; core_wr = 1'b0;
        sd_ack = 1'b0; sd_buff_addr = 8'd0; sd_buff_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
        checkOutput("rst_sd_rd", 32'(sd_rd), 32'd0);
        checkOutput("rst_sd_wr", 32'(sd_wr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_loading", 32'(loading), 32'd0);
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_lba", sd_lba, 32'd0);
        checkOutput("rst_fmt", 32'({bram_b_fmt, fmt_data}), 32'd0);
        checkOutput("rst_we", 32'(bram_b_we), 32'd0);
        reset_n = 1'b1;

        // Load of all sectors.
        $display("[TB] load");
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        checkOutput("load_entry_rd", 32'(sd_rd), 32'd0);
        checkOutput("load_entry_busy", 32'(busy), 32'd1);
        checkOutput("load_entry_loading", 32'(loading), 32'd1);
        @(negedge clk_sys);
        for (int s = 0; s < 16; s++) serveSector(1'b1, s);
        checkOutput("load_total_we", 32'(totalWe), 32'd4096);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Save of all sectors.
        $display("[TB] save");
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk_sys);
        checkOutput("save_entry_wr", 32'(sd_wr), 32'd0);
        checkOutput("save_entry_busy", 32'(busy), 32'd1);
        checkOutput("save_entry_loading", 32'(loading), 32'd0);
        @(negedge clk_sys);
        for (int s = 0; s < 16; s++) serveSector(1'b0, s);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Save edge with no writable save file is ignored.
        bk_ena = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk_sys);
        checkOutput("noena_busy", 32'(busy), 32'd0);
        checkOutput("noena_wr", 32'(sd_wr), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        bk_ena = 1'b1;

        // Format header.
        $display("[TB] format");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkFormat();
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Simultaneous edges: format wins, the rest are dropped.
        $display("[TB] simultaneous");
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkFormat();
        reqCount = 0;
        repeat (30) begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr || busy) reqCount++;
        end
        checkOutput("simul_no_req", 32'(reqCount), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Pending tracking and autosave.
        @(negedge clk_sys);
        core_wr = 1'b1;
        @(negedge clk_sys);
        core_wr = 1'b0;
`ifdef BRAM_AUTOSAVE_EN
        $display("[TB] autosave");
        checkOutput("pending_set", 32'(pending), 32'd1);
        osd_open = 1'b1;
        autosave = 1'b1;
        @(negedge clk_sys);
        checkOutput("pending_clr", 32'(pending), 32'd0);
        checkOutput("auto_busy", 32'(busy), 32'd1);
        @(negedge clk_sys);
        for (int s = 0; s < 16; s++) serveSector(1'b0, s);
`else
        checkOutput("pending_tied", 32'(pending), 32'd0);
        osd_open = 1'b1;
        autosave = 1'b1;
        repeat (3) @(negedge clk_sys);
        checkOutput("no_autosave", 32'(busy), 32'd0);
`endif
        osd_open = 1'b0;
        autosave = 1'b0;

        // Asynchronous reset while sector 7 of a mount-triggered load is requested.
        $display("[TB] reset mid-load");
        @(negedge clk_sys);
        mount_done = 1'b1;
        @(negedge clk_sys);
        mount_done = 1'b0;
        checkOutput("mount_loading", 32'(loading), 32'd1);
        @(negedge clk_sys);
        for (int s = 0; s < 7; s++) serveSector(1'b1, s);
        checkOutput("rst7_rd_before", 32'(sd_rd), 32'd1);
        checkOutput("rst7_lba", sd_lba, 32'd7);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_rd", 32'(sd_rd), 32'd0);
        checkOutput("async_loading", 32'(loading), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        reqCount = 0;
        repeat (20) begin
            @(negedge clk_sys);
            if (sd_rd || sd_wr || busy) reqCount++;
        end
        checkOutput("post_rst_req", 32'(reqCount), 32'd0);
        checkOutput("post_rst_lba", sd_lba, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_save_sequencer.md
# bram_save_sequencer

Controller for the backup-RAM port B and the HPS SD sector channel. It sequences 16-sector load and save transfers between the save file and the two 8-bit backup-RAM halves. It also runs the 4-word format header write and tracks unsaved core writes for autosave. It sits in the emu top level between hps_io (sd_* signals) and the dpram pair, and it holds the core in reset while a load is in progress.

## Interface
Parameters:
- SECTORS, 16, sectors per transfer; must be a power of two, max 16
- LBA_W, 4, sector index width; equals log2(SECTORS)

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- bk_ena  in  1  save file mounted and writable
- load_req  in  1  level; rising edge requests a load
- save_req  in  1  level; rising edge requests a save
- format_req  in  1  level; rising edge requests a format
- mount_done  in  1  one-cycle pulse; cart download ended with a non-empty save image
- osd_open  in  1  OSD visible
- autosave  in  1  autosave enabled
- core_wr  in  1  core backup-RAM write strobe
- sd_lba  out  32  sector number; bits above LBA_W are always 0
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  HPS transfer acknowledge
- sd_buff_addr  in  8  word address within the sector
- sd_buff_wr  in  1  HPS buffer write strobe
- bram_b_addr  out  12  port-B word address
- bram_b_we  out  1  port-B write enable
- bram_b_fmt  out  1  1 = port-B data comes from fmt_data; 0 = from sd_buff_dout
- fmt_data  out  16  format header word
- busy  out  1  transfer or format in progress
- loading  out  1  load in progress; ORed into the core reset
- pending  out  1  unsaved core writes exist

## Operation
- States: IDLE, REQ, WAIT_END, NEXT, FORMAT.
- Edge detection: load_req, save_req and format_req each have a registered previous value.
- IDLE accept priority: format edge > load edge / mount_done > save edge > autosave trigger.
  - Load, save and autosave start only when bk_ena = 1.
  - Format starts regardless of bk_ena.
  - Any event that loses on priority is dropped, not queued.
- Starting a load or save:
  - sd_lba <= 0.
  - loading <= 1 for a load.
  - Go to REQ.
- REQ:
  - Drive sd_rd = loading and sd_wr = ~loading.
  - On the sd_ack rising edge, clear sd_rd and sd_wr, then go to WAIT_END.
- WAIT_END:
  - On the sd_ack falling edge, if sd_lba == SECTORS-1, go to IDLE and clear loading.
  - Otherwise go to NEXT.
- NEXT: sd_lba <= sd_lba + 1, then go to REQ.
- Port-B address and write enable during a transfer:
  - bram_b_addr = {sd_lba[LBA_W-1:0], sd_buff_addr}, zero-extended to 12 bits.
  - bram_b_we = sd_buff_wr & sd_ack & loading.
- FORMAT: a 2-bit counter steps through words 0..3, one per cycle.
  - bram_b_fmt = 1, bram_b_we = 1, bram_b_addr = counter.
  - fmt_data = 0x5548, 0x4D42, 0x8800, 0x8010 for words 0..3.
  - After word 3, go to IDLE.
- busy = (state != IDLE).
- Outside FORMAT, bram_b_fmt = 0. In IDLE, bram_b_we = 0.
- bk_ena falling mid-transfer is ignored; the transfer runs to completion.

## Timing
- All outputs are registered, except bram_b_addr and bram_b_we, which are combinational from sd_* inputs during transfers.
- Reset values: every output is 0; state = IDLE; edge registers are 0.
- Request latency: an edge sampled at clock edge N puts sd_rd or sd_wr high after edge N+1, and holds it until the cycle after the sd_ack rising edge is seen.
- Sector-to-sector: the next request asserts 2 cycles after the sd_ack falling edge.
- Format takes 4 cycles of bram_b_we plus 1 entry cycle; busy is high for 5 cycles.
- Asynchronous reset mid-operation immediately clears sd_rd, sd_wr, loading and busy; no sector is resumed afterwards.

## Configuration
Macro `BRAM_AUTOSAVE_EN`.

With the macro defined:
- pending is set when core_wr & bk_ena & ~osd_open.
- pending is cleared on the cycle a save leaves IDLE. Clear wins over a simultaneous set.
- An autosave trigger is the rising edge of (pending & osd_open & autosave). It starts a save.

Without the macro:
- pending is tied to 0.
- core_wr and autosave are unused.
- Only explicit requests start a save.

## Structure
- Shared package bram_save_pkg holds:
  - the state enum;
  - the SECTORS default;
  - the 4-entry format header constant array.
- No sub-module is needed: the edge detectors, the sector counter and the format counter are all inline.

## Test plan
- Load: bk_ena=1, load_req 0→1; the HPS model acks 16 sectors and writes 256 words each. Required: sd_rd pulses for lba 0..15 and sd_wr never asserts. bram_b_we fires 4096 times at addresses {lba, word}. loading falls after sector 15.
- Save: save_req edge. Required: sd_wr for lba 0..15, bram_b_we stays 0, busy returns to 0 after the final ack falls.
- Format: format_req edge. Required: exactly 4 writes at addresses 0..3 with data 0x5548, 0x4D42, 0x8800, 0x8010, then IDLE.
- Simultaneous: format, load and save edges in the same cycle. Required: only the format runs and no sd request is issued afterwards.
- Autosave (macro on): core_wr while osd_open=0 sets pending. Then osd_open=1 with autosave=1 starts a save; pending clears on that cycle.
- Reset at sector 7 of a load: sd_rd and loading go to 0 asynchronously. After release, sd_lba=0 and no new request is issued.
